audio_record_ctrl: RTL and testbench
====================================

Name: audio_record_ctrl

Overview:
- Sequences an 8-bit single-port block RAM for the audio recorder path: captures mic samples while record is held, then loops them back on playback.
- Sits between the sampled ADC stream (sample trigger at ~48 kHz) and the volume-control/PWM output chain.
- Owns all BRAM addressing and write-enable timing, recorded-length bookkeeping and the output sample register.

Parameters:
ADDR_W, 16, BRAM address width; depth = 2**ADDR_W samples.
DATA_W, 8, sample width (signed PCM).

Ports:
clk_in  input  1  system clock (100 MHz)
rst_in  input  1  reset
record_in  input  1  level, debounced; 1 = record, 0 = play back
ready_in  input  1  one-cycle sample strobe; spacing >= 4 cycles guaranteed
sample_in  input  DATA_W  signed mic sample, valid when ready_in=1
bram_addr_out  output  ADDR_W  BRAM address
bram_we_out  output  1  BRAM write enable
bram_din_out  output  DATA_W  BRAM write data
bram_dout_in  input  DATA_W  BRAM read data, 1-cycle read latency
data_out  output  DATA_W  signed sample to output chain
state_out  output  2  0=IDLE, 1=RECORD, 2=PLAY
len_out  output  ADDR_W+1  number of recorded samples (0..2**ADDR_W)
full_out  output  1  record buffer full

Behaviour:
- Interface: one clock, clk_in; reset is asynchronous and active-high (rst_in). All state is on posedge clk_in.
- Reset values: state IDLE, bram_addr_out=0, bram_we_out=0, bram_din_out=0, data_out=0, len_out=0, full_out=0, record_in edge register=0.
- Reset mid-operation clears everything immediately, including an in-flight write; the recording is lost (len_out=0).
- Edge detect: rec_q <= record_in each cycle. Rise = record_in & ~rec_q. Fall = ~record_in & rec_q.
- Priority per cycle: edge event > ready_in. A ready_in coinciding with an edge is dropped.
- IDLE: data_out=0, we=0. Rise -> RECORD. ready_in ignored.
- Entering RECORD (from any state on a rise): addr<=0, len<=0, full<=0, we<=0.
- RECORD, on ready_in with full_out=0:
  - Cycle N: we<=1, din<=sample_in, data_out<=sample_in (monitor).
  - Cycle N+1: we<=0, len<=len+1, addr<=addr+1 (wraps to 0 at 2**ADDR_W-1).
  - If len+1 == 2**ADDR_W, full<=1.
- RECORD while full_out=1: ready_in writes nothing, but data_out still mirrors sample_in. Stay in RECORD until the fall.
- RECORD fall:
  - len_out>0: -> PLAY, addr<=0.
  - len_out==0: -> IDLE, data_out<=0.
  - If the fall lands in cycle N+1 of a write, the write's len/addr update still completes that cycle. The len used for the decision includes it.
- PLAY:
  - bram_addr_out is held stable between strobes, so bram_dout_in is valid at each ready_in.
  - On ready_in: data_out<=bram_dout_in. addr<=(addr+1==len) ? 0 : addr+1, giving a loop of exactly len_out samples.
  - data_out updates the cycle after ready_in and holds until the next strobe. we stays 0. len_out and full_out are held.
- PLAY rise -> RECORD (new recording overwrites from address 0). PLAY fall: impossible (record_in already 0).
- Width rules: len_out is ADDR_W+1 wide so a full buffer reads 2**ADDR_W. Comparisons zero-extend addr.
- bram_we_out is never high for more than 1 cycle per strobe, and never high outside RECORD.

Test Plan:
- Reset: assert rst_in async mid-RECORD with we=1 -> all outputs 0 within the same cycle, state_out=0, len_out=0.
- Basic loop (ADDR_W=4): rise, 5 strobes with samples 10,-3,7,0,127, then fall.
  - Record: we pulses at addrs 0..4, len_out=5.
  - Play: 12 strobes produce data_out 10,-3,7,0,127,10,-3,7,0,127,10,-3.
- Full (ADDR_W=4): record 20 strobes.
  - After strobe 16: full_out=1, len_out=16.
  - Strobes 17-20 produce no we pulses.
  - Playback loops 16 samples, addr wraps 15->0.
- Empty record: rise then fall with no strobes -> state IDLE, len_out=0, data_out=0; later strobes give no we and data_out=0.
- Simultaneous: rise coincident with ready_in in PLAY -> state RECORD, addr=0, no write that cycle, data_out unchanged. The next strobe writes addr 0.
- Re-record: in PLAY with len_out=5, raise record_in and record 3 samples, then fall -> playback loops only the 3 new samples.

Source files
------------

// File: rtl/audio_record_ctrl_if.sv
// Sample-stream, BRAM and status signals of the audio record/playback sequencer.
// The master drives the stream and BRAM read data; the slave (the controller) drives the rest.
interface audio_record_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              record_in;
  logic              ready_in;
  logic [DATA_W-1:0] sample_in;
  logic [ADDR_W-1:0] bram_addr_out;
  logic              bram_we_out;
  logic [DATA_W-1:0] bram_din_out;
  logic [DATA_W-1:0] bram_dout_in;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        state_out;
  logic [ADDR_W:0]   len_out;
  logic              full_out;

  modport master (
    output record_in, ready_in, sample_in, bram_dout_in,
    input  bram_addr_out, bram_we_out, bram_din_out, data_out, state_out, len_out, full_out
  );

  modport slave (
    input  record_in, ready_in, sample_in, bram_dout_in,
    output bram_addr_out, bram_we_out, bram_din_out, data_out, state_out, len_out, full_out
  );
endinterface

// File: rtl/audio_record_ctrl.sv
// Record/playback sequencer for a single-port sample BRAM: records mic samples while
// record_in is held, then loops the recorded length back to the output chain.
module audio_record_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic                clk_in,
  input  logic                rst_in,
  audio_record_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_PLAY   = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic              rec_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              full_q, full_d;

  logic              rise, fall;
  logic [ADDR_W:0]   len_inc;
  logic [ADDR_W:0]   addr_ext_inc;

  assign rise         = bus.record_in & ~rec_q;
  assign fall         = ~bus.record_in & rec_q;
  assign len_inc      = len_q + (ADDR_W+1)'(1);
  assign addr_ext_inc = {1'b0, addr_q} + (ADDR_W+1)'(1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    din_d   = din_q;
    data_d  = data_q;
    len_d   = len_q;
    full_d  = full_q;

    // we_q high marks the cycle after a write: commit length and advance the address
    if (state_q == ST_RECORD && we_q) begin
      len_d  = len_inc;
      addr_d = addr_q + ADDR_W'(1);
      if (len_inc == DEPTH) begin
        full_d = 1'b1;
      end
    end

    if (rise) begin
      state_d = ST_RECORD;
      addr_d  = '0;
      len_d   = '0;
      full_d  = 1'b0;
    end else if (fall && state_q == ST_RECORD) begin
      // len_d already includes a write completing this cycle
      if (len_d != '0) begin
        state_d = ST_PLAY;
        addr_d  = '0;
      end else begin
        state_d = ST_IDLE;
        data_d  = '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          data_d = '0;
        end
        ST_RECORD: begin
          if (bus.ready_in) begin
            data_d = bus.sample_in;
            if (!full_q) begin
              we_d  = 1'b1;
              din_d = bus.sample_in;
            end
          end
        end
        ST_PLAY: begin
          if (bus.ready_in) begin
            data_d = bus.bram_dout_in;
            addr_d = (addr_ext_inc == len_q) ? '0 : addr_q + ADDR_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          data_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      rec_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      din_q   <= '0;
      data_q  <= '0;
      len_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rec_q   <= bus.record_in;
      addr_q  <= addr_d;
      we_q    <= we_d;
      din_q   <= din_d;
      data_q  <= data_d;
      len_q   <= len_d;
      full_q  <= full_d;
    end
  end

  assign bus.bram_addr_out = addr_q;
  assign bus.bram_we_out   = we_q;
  assign bus.bram_din_out  = din_q;
  assign bus.data_out      = data_q;
  assign bus.state_out     = state_q;
  assign bus.len_out       = len_q;
  assign bus.full_out      = full_q;

endmodule

// File: tb/tb_audio_record_ctrl.sv
// Directed bench for audio_record_ctrl with a 16-deep BRAM model: table-driven record and
// playback strobes plus hand-written sequences for reset, edge collisions and the full buffer.
module tb_audio_record_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;

  typedef struct {
    logic [DW-1:0] smp;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic [AW:0]   exp_len;
  } vec_t;

  logic clk_in = 1'b0;
  logic rst_in;
  int   total = 0;
  int   bad   = 0;

  logic [DW-1:0] mem [16];

  always #5 clk_in = ~clk_in;

  audio_record_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  audio_record_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  // Single-port BRAM, read-first, one cycle read latency
  always @(posedge clk_in) begin
    if (bus.bram_we_out) mem[bus.bram_addr_out] <= bus.bram_din_out;
    bus.bram_dout_in <= mem[bus.bram_addr_out];
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(bus.state_out), 0);
    check({tag, "_addr"},  32'(bus.bram_addr_out), 0);
    check({tag, "_we"},    32'(bus.bram_we_out), 0);
    check({tag, "_din"},   32'(bus.bram_din_out), 0);
    check({tag, "_data"},  32'(bus.data_out), 0);
    check({tag, "_len"},   32'(bus.len_out), 0);
    check({tag, "_full"},  32'(bus.full_out), 0);
  endtask

  // One record strobe; strobes are spaced 4 cycles apart
  task automatic apply_rec(input vec_t v);
    bus.ready_in  = 1'b1;
    bus.sample_in = v.smp;
    tick();
    bus.ready_in = 1'b0;
    check("rec_we",   32'(bus.bram_we_out), 32'(v.exp_we));
    check("rec_addr", 32'(bus.bram_addr_out), 32'(v.exp_addr));
    check("rec_mon",  32'(bus.data_out), 32'(v.exp_data));
    if (v.exp_we) check("rec_din", 32'(bus.bram_din_out), 32'(v.smp));
    $display("rec  smp=%02h we=%0d addr=%0d data=%02h", v.smp, bus.bram_we_out, bus.bram_addr_out, bus.data_out);
    tick();
    check("rec_len",    32'(bus.len_out), 32'(v.exp_len));
    check("rec_we_clr", 32'(bus.bram_we_out), 0);
    tick();
    tick();
  endtask

  // One playback strobe; exp_addr is the address after the strobe
  task automatic apply_play(input vec_t v);
    bus.ready_in  = 1'b1;
    bus.sample_in = 8'hA5;
    tick();
    bus.ready_in = 1'b0;
    check("play_data", 32'(bus.data_out), 32'(v.exp_data));
    check("play_addr", 32'(bus.bram_addr_out), 32'(v.exp_addr));
    check("play_we",   32'(bus.bram_we_out), 0);
    $display("play data=%02h next_addr=%0d len=%0d", bus.data_out, bus.bram_addr_out, bus.len_out);
    tick();
    tick();
    tick();
  endtask

  initial begin
    vec_t basic_rec [5];
    vec_t basic_play [12];
    vec_t new_rec [3];
    vec_t new_play [5];
    vec_t full_rec [20];
    vec_t full_play [18];
    logic [DW-1:0] basic_smp [5];

    basic_smp = '{8'd10, 8'hFD, 8'd7, 8'd0, 8'd127};
    for (int i = 0; i < 5; i++)
      basic_rec[i] = '{basic_smp[i], 1'b1, AW'(i), basic_smp[i], (AW+1)'(i + 1)};
    for (int i = 0; i < 12; i++)
      basic_play[i] = '{8'h00, 1'b0, AW'((i + 1) % 5), basic_smp[i % 5], 5'd5};
    new_rec[0] = '{8'h11, 1'b1, 4'd0, 8'h11, 5'd1};
    new_rec[1] = '{8'h22, 1'b1, 4'd1, 8'h22, 5'd2};
    new_rec[2] = '{8'h33, 1'b1, 4'd2, 8'h33, 5'd3};
    new_play[0] = '{8'h00, 1'b0, 4'd1, 8'h11, 5'd3};
    new_play[1] = '{8'h00, 1'b0, 4'd2, 8'h22, 5'd3};
    new_play[2] = '{8'h00, 1'b0, 4'd0, 8'h33, 5'd3};
    new_play[3] = '{8'h00, 1'b0, 4'd1, 8'h11, 5'd3};
    new_play[4] = '{8'h00, 1'b0, 4'd2, 8'h22, 5'd3};
    for (int i = 0; i < 20; i++)
      full_rec[i] = '{DW'(i + 1), (i < 16), (i < 16) ? AW'(i) : AW'(0), DW'(i + 1),
                      (i < 16) ? (AW+1)'(i + 1) : (AW+1)'(16)};
    for (int i = 0; i < 18; i++)
      full_play[i] = '{8'h00, 1'b0, AW'((i + 1) % 16), DW'((i % 16) + 1), 5'd16};

    rst_in        = 1'b1;
    bus.record_in = 1'b0;
    bus.ready_in  = 1'b0;
    bus.sample_in = '0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_in = 1'b0;
    tick();

    // Basic record of 5 samples, then 12-strobe loop
    bus.record_in = 1'b1;
    tick();
    check("rise_state", 32'(bus.state_out), 1);
    tick();
    for (int i = 0; i < 5; i++) apply_rec(basic_rec[i]);
    bus.record_in = 1'b0;
    tick();
    check("fall_state", 32'(bus.state_out), 2);
    check("fall_addr",  32'(bus.bram_addr_out), 0);
    check("fall_len",   32'(bus.len_out), 5);
    tick();
    tick();
    for (int i = 0; i < 12; i++) apply_play(basic_play[i]);
    check("play_full", 32'(bus.full_out), 0);

    // Rise coinciding with a strobe in PLAY: strobe dropped, data_out held
    bus.record_in = 1'b1;
    bus.ready_in  = 1'b1;
    bus.sample_in = 8'h55;
    tick();
    bus.ready_in = 1'b0;
    check("sim_state", 32'(bus.state_out), 1);
    check("sim_addr",  32'(bus.bram_addr_out), 0);
    check("sim_we",    32'(bus.bram_we_out), 0);
    check("sim_data",  32'(bus.data_out), 32'h0FD);
    check("sim_len",   32'(bus.len_out), 0);
    tick();
    tick();
    tick();
    for (int i = 0; i < 3; i++) apply_rec(new_rec[i]);
    bus.record_in = 1'b0;
    tick();
    check("rerec_state", 32'(bus.state_out), 2);
    check("rerec_len",   32'(bus.len_out), 3);
    tick();
    tick();
    for (int i = 0; i < 5; i++) apply_play(new_play[i]);

    // Empty recording returns to IDLE
    bus.record_in = 1'b1;
    tick();
    check("empty_rise", 32'(bus.state_out), 1);
    tick();
    bus.record_in = 1'b0;
    tick();
    check("empty_state", 32'(bus.state_out), 0);
    check("empty_len",   32'(bus.len_out), 0);
    check("empty_data",  32'(bus.data_out), 0);
    tick();
    bus.ready_in  = 1'b1;
    bus.sample_in = 8'h44;
    tick();
    bus.ready_in = 1'b0;
    check("idle_we",   32'(bus.bram_we_out), 0);
    check("idle_data", 32'(bus.data_out), 0);
    $display("idle strobe state=%0d we=%0d data=%02h", bus.state_out, bus.bram_we_out, bus.data_out);
    tick();
    tick();

    // Fill the buffer, overflow strobes write nothing, then loop all 16
    bus.record_in = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      apply_rec(full_rec[i]);
      if (i == 14) check("not_full_15", 32'(bus.full_out), 0);
      if (i == 15) check("full_16", 32'(bus.full_out), 1);
    end
    bus.record_in = 1'b0;
    tick();
    check("full_fall_state", 32'(bus.state_out), 2);
    check("full_fall_len",   32'(bus.len_out), 16);
    check("full_fall_full",  32'(bus.full_out), 1);
    tick();
    tick();
    for (int i = 0; i < 18; i++) apply_play(full_play[i]);

    // Asynchronous reset while a write is in flight
    bus.record_in = 1'b1;
    tick();
    tick();
    bus.ready_in  = 1'b1;
    bus.sample_in = 8'h66;
    tick();
    bus.ready_in = 1'b0;
    check("pre_rst_we", 32'(bus.bram_we_out), 1);
    rst_in = 1'b1;
    #1;
    check_all_zero("async_rst");
    $display("async reset state=%0d we=%0d len=%0d", bus.state_out, bus.bram_we_out, bus.len_out);
    bus.record_in = 1'b0;
    tick();
    rst_in = 1'b0;
    tick();
    check("post_rst_state", 32'(bus.state_out), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
